// File: rtl/xadc_argmax_sweep_if.sv
// DRP port between the XADC primitive (slave) and a DRP reader (master).
// drp_do carries the primitive's DO output; "do" itself is a reserved word in SystemVerilog.
interface xadc_argmax_sweep_if;
    logic [6:0]  daddr;
    logic        den;
    logic        dwe;
    logic [15:0] di;
    logic [15:0] drp_do;
    logic        drdy;

    modport master (output daddr, den, dwe, di, input drp_do, drdy);
    modport slave  (input daddr, den, dwe, di, output drp_do, drdy);
endinterface

// File: rtl/xadc_argmax_sweep.sv
// Reads NUM_CH XADC status registers over DRP after every end-of-sequence and publishes
// the argmax channel. Define XADC_SWEEP_TIMEOUT_EN to abort a sweep on a missing DRDY.
//
// state | meaning
// IDLE  | waiting for eos; drdy ignored
// REQ   | den pulse for channel idx
// WAIT  | waiting for drdy of channel idx
module xadc_argmax_sweep #(
    parameter int         NUM_CH         = 4,
    parameter logic [6:0] BASE_ADDR      = 7'h10,
    parameter int         DATA_W         = 12,
    parameter int         TIMEOUT_CYCLES = 64,
    localparam int        IDX_W          = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       eos,
    xadc_argmax_sweep_if.master        drp,
    output logic [NUM_CH*DATA_W-1:0]   measured,
    output logic [IDX_W-1:0]           network_output,
    output logic [DATA_W-1:0]          max_value,
    output logic                       result_valid,
    output logic                       timeout_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic                den_q, den_nxt;
    logic [6:0]          daddr_q, daddr_nxt;
    logic [DATA_W-1:0]   run_max, run_max_nxt;
    logic [IDX_W-1:0]    run_idx, run_idx_nxt;
    logic [IDX_W-1:0]    net_nxt;
    logic [DATA_W-1:0]   max_nxt;
    logic                valid_nxt;
    logic                capture;
    logic                last_ch;
    logic                better;
    logic [DATA_W-1:0]   sample;
    logic                unused_do;

    assign drp.den   = den_q;
    assign drp.daddr = daddr_q;
    assign drp.dwe   = 1'b0;
    assign drp.di    = '0;

    // Results are left-justified in the status registers; low bits are dropped.
    assign sample    = drp.drp_do[15 -: DATA_W];
    assign unused_do = ^drp.drp_do;
    assign last_ch   = (idx == IDX_W'(NUM_CH - 1));
    assign better    = (idx == '0) || (sample > run_max);

`ifdef XADC_SWEEP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmr, tmr_nxt;
    logic             tout_nxt;
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT_CYCLES;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        den_nxt     = 1'b0;
        daddr_nxt   = '0;
        run_max_nxt = run_max;
        run_idx_nxt = run_idx;
        net_nxt     = network_output;
        max_nxt     = max_value;
        valid_nxt   = 1'b0;
        capture     = 1'b0;
`ifdef XADC_SWEEP_TIMEOUT_EN
        tmr_nxt     = tmr;
        tout_nxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (eos) begin
                    state_nxt = REQ;
                    idx_nxt   = '0;
                    den_nxt   = 1'b1;
                    daddr_nxt = BASE_ADDR;
                end
            end
            REQ: begin
                state_nxt = WAIT;
`ifdef XADC_SWEEP_TIMEOUT_EN
                tmr_nxt   = CNT_W'(TIMEOUT_CYCLES);
`endif
            end
            WAIT: begin
                if (drp.drdy) begin
                    capture     = 1'b1;
                    run_max_nxt = better ? sample : run_max;
                    run_idx_nxt = better ? idx : run_idx;
                    if (last_ch) begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b1;
                        net_nxt   = run_idx_nxt;
                        max_nxt   = run_max_nxt;
                    end else begin
                        state_nxt = REQ;
                        idx_nxt   = idx + 1'b1;
                        den_nxt   = 1'b1;
                        daddr_nxt = BASE_ADDR + 7'(idx) + 7'd1;
                    end
                end
`ifdef XADC_SWEEP_TIMEOUT_EN
                // Down-counter: the cycle it would hit zero without drdy is the timeout.
                else if (tmr == CNT_W'(1)) begin
                    state_nxt = IDLE;
                    tout_nxt  = 1'b1;
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            den_q          <= 1'b0;
            daddr_q        <= '0;
            run_max        <= '0;
            run_idx        <= '0;
            network_output <= '0;
            max_value      <= '0;
            result_valid   <= 1'b0;
            measured       <= '0;
`ifdef XADC_SWEEP_TIMEOUT_EN
            tmr            <= '0;
            timeout_err    <= 1'b0;
`endif
        end else begin
            state          <= state_nxt;
            idx            <= idx_nxt;
            den_q          <= den_nxt;
            daddr_q        <= daddr_nxt;
            run_max        <= run_max_nxt;
            run_idx        <= run_idx_nxt;
            network_output <= net_nxt;
            max_value      <= max_nxt;
            result_valid   <= valid_nxt;
            if (capture) begin
                measured[int'(idx)*DATA_W +: DATA_W] <= sample;
            end
`ifdef XADC_SWEEP_TIMEOUT_EN
            tmr            <= tmr_nxt;
            timeout_err    <= tout_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_xadc_argmax_sweep.sv
// Directed bench for xadc_argmax_sweep: a 4-channel and an 8-channel instance on one clock.
module tb_xadc_argmax_sweep;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic eos4 = 1'b0;
    logic eos8 = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    xadc_argmax_sweep_if if4 ();
    xadc_argmax_sweep_if if8 ();

    logic [47:0] meas4;
    logic [1:0]  net4;
    logic [11:0] max4;
    logic        rv4, te4;
    logic [95:0] meas8;
    logic [2:0]  net8;
    logic [11:0] max8;
    logic        rv8, te8;

    xadc_argmax_sweep #(.NUM_CH(4), .BASE_ADDR(7'h10), .DATA_W(12), .TIMEOUT_CYCLES(16)) dut4 (
        .clk(clk), .rst(rst), .eos(eos4), .drp(if4),
        .measured(meas4), .network_output(net4), .max_value(max4),
        .result_valid(rv4), .timeout_err(te4)
    );

    xadc_argmax_sweep #(.NUM_CH(8), .BASE_ADDR(7'h18), .DATA_W(12), .TIMEOUT_CYCLES(16)) dut8 (
        .clk(clk), .rst(rst), .eos(eos8), .drp(if8),
        .measured(meas8), .network_output(net8), .max_value(max8),
        .result_valid(rv8), .timeout_err(te8)
    );

    // sel picks which instance the sweep task drives and observes.
    logic       sel = 1'b0;
    logic       s_den, s_rv, s_te;
    logic [6:0] s_daddr;
    assign s_den   = sel ? if8.den   : if4.den;
    assign s_daddr = sel ? if8.daddr : if4.daddr;
    assign s_rv    = sel ? rv8 : rv4;
    assign s_te    = sel ? te8 : te4;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_eos(input logic v);
        if (sel) eos8 = v;
        else     eos4 = v;
    endtask

    task automatic set_drdy(input logic v, input logic [15:0] d);
        if (sel) begin
            if8.drdy = v; if8.drp_do = d;
        end else begin
            if4.drdy = v; if4.drp_do = d;
        end
    endtask

    // Called at a negedge: raises eos (cycle 0), answers each den after dly extra cycles,
    // and returns at the negedge of the cycle where result_valid or timeout_err is seen.
    task automatic sweep(input int n, input logic [6:0] base, input logic [95:0] vals,
                         input int dly, input int eos_again, input int stall_ch,
                         output int done_cyc, output int den_cnt, output logic timed_out);
        int   ch = 0;
        int   drdy_at = -1;
        logic den_prev = 1'b0;
        done_cyc  = -1;
        den_cnt   = 0;
        timed_out = 1'b0;
        set_eos(1'b1);
        for (int k = 1; k <= 400 && done_cyc < 0; k++) begin
            @(negedge clk);
            set_eos(k == eos_again);
            set_drdy(1'b0, 16'h0);
            if (s_rv || s_te) begin
                check("rv_te_exclusive", 128'(s_rv & s_te), 128'(0));
                done_cyc  = k;
                timed_out = s_te;
            end else begin
                if (s_den) begin
                    den_cnt++;
                    check("den_one_cycle", 128'(den_prev), 128'(0));
                    check("daddr", 128'(s_daddr), 128'(base + 7'(ch)));
                    if (ch != stall_ch) drdy_at = k + 1 + dly;
                end
                if (k == drdy_at && ch < n) begin
                    set_drdy(1'b1, {vals[ch*12 +: 12], 4'hA});
                    ch++;
                end
                den_prev = s_den;
            end
        end
        if (done_cyc < 0) begin
            checks++;
            errors++;
            $error("FAIL sweep_bound: no result_valid/timeout_err within 400 cycles, observed none expected one (n=%0d)", n);
        end
    endtask

    initial begin
        int   dc, dn;
        logic to;
        logic bad;
        if4.drdy = 1'b0; if4.drp_do = 16'h0;
        if8.drdy = 1'b0; if8.drp_do = 16'h0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_meas4", 128'(meas4), 128'(0));
        check("rst_net4",  128'(net4),  128'(0));
        check("rst_max4",  128'(max4),  128'(0));
        check("rst_rv4",   128'(rv4),   128'(0));
        check("rst_te4",   128'(te4),   128'(0));
        check("rst_den4",  128'(if4.den),   128'(0));
        check("rst_daddr4",128'(if4.daddr), 128'(0));
        check("rst_meas8", 128'(meas8), 128'(0));
        check("rst_net8",  128'(net8),  128'(0));
        rst = 1'b0;
        @(negedge clk);

        // Basic 4-channel sweep, minimum latency
        sel = 1'b0;
        sweep(4, 7'h10, 96'(48'h050_200_300_100), 0, -1, -1, dc, dn, to);
        check("t1_valid_cycle", 128'(dc), 128'(9));
        check("t1_den_count",   128'(dn), 128'(4));
        check("t1_no_timeout",  128'(to), 128'(0));
        check("t1_net",  128'(net4),  128'(1));
        check("t1_max",  128'(max4),  128'(12'h300));
        check("t1_meas", 128'(meas4), 128'(48'h050_200_300_100));
        check("t1_dwe",  128'(if4.dwe), 128'(0));
        check("t1_di",   128'(if4.di),  128'(0));

        // Ties, started back-to-back in the result_valid cycle
        sweep(4, 7'h10, 96'(48'h200_1FF_200_200), 0, -1, -1, dc, dn, to);
        check("t2_valid_cycle", 128'(dc), 128'(9));
        check("t2_net", 128'(net4), 128'(0));
        check("t2_max", 128'(max4), 128'(12'h200));

        // 8 channels, base 0x18, drdy delayed 3 cycles per read
        sel = 1'b1;
        sweep(8, 7'h18, 96'hFFF_800_001_FFE_0AB_789_456_123, 3, -1, -1, dc, dn, to);
        check("t3_valid_cycle", 128'(dc), 128'(41));
        check("t3_den_count",   128'(dn), 128'(8));
        check("t3_net",  128'(net8),  128'(7));
        check("t3_max",  128'(max8),  128'(12'hFFF));
        check("t3_meas", 128'(meas8), 128'(96'hFFF_800_001_FFE_0AB_789_456_123));
        sel = 1'b0;

        // eos pulsed mid-sweep is ignored and not queued
        sweep(4, 7'h10, 96'(48'h00D_C00_00B_00A), 0, 4, -1, dc, dn, to);
        check("t4_valid_cycle", 128'(dc), 128'(9));
        check("t4_den_count",   128'(dn), 128'(4));
        check("t4_net", 128'(net4), 128'(2));
        check("t4_max", 128'(max4), 128'(12'hC00));
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bad = bad | if4.den | rv4;
        end
        check("t4_no_requeue", 128'(bad), 128'(0));
        check("t4_net_hold",   128'(net4), 128'(2));
        sweep(4, 7'h10, 96'(48'h000_001_800_7FF), 0, -1, -1, dc, dn, to);
        check("t4b_net", 128'(net4), 128'(1));
        check("t4b_max", 128'(max4), 128'(12'h800));

        // Reset while waiting for channel 2, then a stale drdy
        set_eos(1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            set_eos(1'b0);
            set_drdy(k == 2 || k == 4, {12'h3C3, 4'hA});
        end
        check("t5_den_ch2",   128'(if4.den),   128'(1));
        check("t5_daddr_ch2", 128'(if4.daddr), 128'(7'h12));
        @(negedge clk);
        check("t5_meas_partial", 128'(meas4[23:0]), 128'(24'h3C3_3C3));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_drdy(1'b1, {12'hEEE, 4'hA});
        @(negedge clk);
        set_drdy(1'b0, 16'h0);
        @(negedge clk);
        check("t5_meas", 128'(meas4), 128'(0));
        check("t5_net",  128'(net4),  128'(0));
        check("t5_max",  128'(max4),  128'(0));
        check("t5_den",  128'(if4.den),   128'(0));
        check("t5_daddr",128'(if4.daddr), 128'(0));
        check("t5_rv",   128'(rv4), 128'(0));
        check("t5_net8", 128'(net8), 128'(0));
        sweep(4, 7'h10, 96'(48'h004_003_002_001), 0, -1, -1, dc, dn, to);
        check("t5b_valid_cycle", 128'(dc), 128'(9));
        check("t5b_net", 128'(net4), 128'(3));
        check("t5b_max", 128'(max4), 128'(12'h004));

`ifdef XADC_SWEEP_TIMEOUT_EN
        // drdy withheld on channel 1: WAIT entered at end of cycle 3, abort seen in cycle 20
        sweep(4, 7'h10, 96'(48'h000_000_000_111), 0, -1, 1, dc, dn, to);
        check("t6_timeout",     128'(to), 128'(1));
        check("t6_abort_cycle", 128'(dc), 128'(20));
        check("t6_den_count",   128'(dn), 128'(2));
        check("t6_net_hold",    128'(net4),  128'(3));
        check("t6_max_hold",    128'(max4),  128'(12'h004));
        check("t6_meas",        128'(meas4), 128'(48'h004_003_002_111));
        sweep(4, 7'h10, 96'(48'h005_030_020_010), 0, -1, -1, dc, dn, to);
        check("t6b_valid_cycle", 128'(dc), 128'(9));
        check("t6b_no_timeout",  128'(to), 128'(0));
        check("t6b_net", 128'(net4), 128'(2));
        check("t6b_max", 128'(max4), 128'(12'h030));
`else
        check("t6_te_low", 128'(te4 | te8), 128'(0));
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
